// File: rtl/mc_control_if.sv
// mc_control_if: unified instruction/data memory handshake between the
// multicycle controller (master) and the memory (slave).
interface mc_control_if;
    logic mem_read;
    logic mem_write;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/mc_control.sv
// mc_control: multicycle main controller for the MIPS-subset CPU.
// Sequences fetch/decode/execute/memory/writeback over a shared ALU and a
// unified memory port, stalling on the memory ready handshake.
// Optional feature: define MC_CONTROL_ADDI_EN to decode addi (ADDIEX/ADDIWB);
// otherwise opcode 001000 is illegal.
module mc_control (
    input  logic              clk,
    input  logic              rst_n,
    mc_control_if.master      mem,
    input  logic [5:0]        opcode,
    input  logic              zero,
    output logic              ir_write,
    output logic              pc_en,
    output logic [1:0]        pc_src,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        aluop,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic [3:0]        state,
    output logic              illegal
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    state_t cur, nxt;

    assign state = cur;

    // State register; reset forces FETCH and aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= FETCH;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state and output decode; every output is forced low while in reset
    // so no strobe or write can leak out before the first fetch.
    always_comb begin
        nxt           = FETCH;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.iord      = 1'b0;
        ir_write      = 1'b0;
        pc_en         = 1'b0;
        pc_src        = '0;
        alu_src_a     = 1'b0;
        alu_src_b     = '0;
        aluop         = '0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal       = 1'b0;

        case (cur)
            FETCH: begin
                mem.mem_read = 1'b1;
                alu_src_b    = 2'b01;
                ir_write     = mem.mem_ready;
                pc_en        = mem.mem_ready;
                nxt          = mem.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_R:         nxt = EXEC;
                    OP_BEQ:       nxt = BRANCH;
                    OP_J:         nxt = JUMP;
`ifdef MC_CONTROL_ADDI_EN
                    OP_ADDI:      nxt = ADDIEX;
`endif
                    default: begin
                        illegal = 1'b1;
                        nxt     = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW) begin
                    nxt = MEMRD;
                end else if (opcode == OP_SW) begin
                    nxt = MEMWR;
                end else begin
                    nxt = FETCH;
                end
            end
            MEMRD: begin
                mem.mem_read = 1'b1;
                mem.iord     = 1'b1;
                nxt          = mem.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem.mem_write = 1'b1;
                mem.iord      = 1'b1;
                nxt           = mem.mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                aluop     = 2'b10;
                nxt       = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = 2'b01;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
`ifdef MC_CONTROL_ADDI_EN
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
`endif
            default: begin
                nxt = FETCH;
            end
        endcase

        if (!rst_n) begin
            mem.mem_read  = 1'b0;
            mem.mem_write = 1'b0;
            mem.iord      = 1'b0;
            ir_write      = 1'b0;
            pc_en         = 1'b0;
            pc_src        = '0;
            alu_src_a     = 1'b0;
            alu_src_b     = '0;
            aluop         = '0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            illegal       = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed stimulus for mc_control. Each step drives the
// inputs for one clock cycle, pushes the expected output vector into a
// scoreboard queue, and pops/compares once the DUT outputs have settled.
module tb_mc_control;

    typedef struct packed {
        logic [3:0] st;
        logic       mr;
        logic       mw;
        logic       io;
        logic       irw;
        logic       pce;
        logic [1:0] pcs;
        logic       asa;
        logic [1:0] asb;
        logic [1:0] aop;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       ill;
    } outs_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       ir_write, pc_en, alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
    logic [1:0] pc_src, alu_src_b, aluop;
    logic [3:0] state;

    int unsigned checks;
    int unsigned failures;

    outs_t exp_q[$];
    string tag_q[$];

    mc_control_if bus ();

    mc_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (bus.master),
        .opcode     (opcode),
        .zero       (zero),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .aluop      (aluop),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .state      (state),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vectors, written straight from the per-state output table.
    function automatic outs_t mk(input logic [3:0] st, input logic mr, input logic mw,
                                 input logic io, input logic irw, input logic pce,
                                 input logic [1:0] pcs, input logic asa,
                                 input logic [1:0] asb, input logic [1:0] aop,
                                 input logic rw, input logic rd, input logic m2r,
                                 input logic ill);
        outs_t o;
        o = '{st, mr, mw, io, irw, pce, pcs, asa, asb, aop, rw, rd, m2r, ill};
        return o;
    endfunction

    function automatic outs_t e_reset();
        return mk(4'd0, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0,0);
    endfunction
    function automatic outs_t e_fetch(input logic rdy);
        return mk(4'd0, 1,0,0,rdy,rdy, 2'b00, 0, 2'b01, 2'b00, 0,0,0,0);
    endfunction
    function automatic outs_t e_decode(input logic ill);
        return mk(4'd1, 0,0,0,0,0, 2'b00, 0, 2'b11, 2'b00, 0,0,0,ill);
    endfunction

    function automatic outs_t observed();
        return '{state, bus.mem_read, bus.mem_write, bus.iord, ir_write, pc_en, pc_src,
                 alu_src_a, alu_src_b, aluop, reg_write, reg_dst, mem_to_reg, illegal};
    endfunction

    // One clock cycle: drive at the falling edge, record the expectation,
    // then compare against the settled outputs before the next rising edge.
    task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                       input logic z, input logic rdy, input outs_t e);
        outs_t got, want;
        string t;
        @(negedge clk);
        rst_n         = rst;
        opcode        = op;
        zero          = z;
        bus.mem_ready = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        got  = observed();
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", t, got, want);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        opcode        = OP_R;
        zero          = 1'b0;
        bus.mem_ready = 1'b1;

        // Reset held with ready high: nothing issued, FETCH state.
        cyc("reset0", 0, OP_R, 0, 1, e_reset());
        cyc("reset1", 0, OP_R, 0, 1, e_reset());

        // First fetch waits one cycle on memory, then lw with ready high.
        cyc("fetch_wait", 1, OP_LW, 0, 0, e_fetch(0));
        cyc("lw_fetch",   1, OP_LW, 0, 1, e_fetch(1));
        cyc("lw_decode",  1, OP_LW, 0, 0, e_decode(0));
        cyc("lw_memadr",  1, OP_LW, 0, 1, mk(4'd2, 0,0,0,0,0, 2'b00, 1, 2'b10, 2'b00, 0,0,0,0));
        cyc("lw_memrd",   1, OP_LW, 0, 1, mk(4'd3, 1,0,1,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0,0));
        cyc("lw_memwb",   1, OP_LW, 0, 1, mk(4'd4, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1,0,1,0));

        // sw with three wait cycles in MEMWR: 7 cycles total.
        cyc("sw_fetch",   1, OP_SW, 0, 1, e_fetch(1));
        cyc("sw_decode",  1, OP_SW, 0, 1, e_decode(0));
        cyc("sw_memadr",  1, OP_SW, 0, 1, mk(4'd2, 0,0,0,0,0, 2'b00, 1, 2'b10, 2'b00, 0,0,0,0));
        for (int i = 0; i < 3; i++) begin
            cyc("sw_memwr_wait", 1, OP_SW, 0, 0, mk(4'd5, 0,1,1,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0,0));
        end
        cyc("sw_memwr_done", 1, OP_SW, 0, 1, mk(4'd5, 0,1,1,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0,0));

        // beq taken.
        cyc("beq1_fetch",  1, OP_BEQ, 1, 1, e_fetch(1));
        cyc("beq1_decode", 1, OP_BEQ, 1, 1, e_decode(0));
        cyc("beq1_branch", 1, OP_BEQ, 1, 1, mk(4'd8, 0,0,0,0,1, 2'b01, 1, 2'b00, 2'b01, 0,0,0,0));

        // beq not taken.
        cyc("beq0_fetch",  1, OP_BEQ, 0, 1, e_fetch(1));
        cyc("beq0_decode", 1, OP_BEQ, 0, 1, e_decode(0));
        cyc("beq0_branch", 1, OP_BEQ, 0, 1, mk(4'd8, 0,0,0,0,0, 2'b01, 1, 2'b00, 2'b01, 0,0,0,0));

        // R-type.
        cyc("r_fetch",  1, OP_R, 0, 1, e_fetch(1));
        cyc("r_decode", 1, OP_R, 0, 1, e_decode(0));
        cyc("r_exec",   1, OP_R, 0, 1, mk(4'd6, 0,0,0,0,0, 2'b00, 1, 2'b00, 2'b10, 0,0,0,0));
        cyc("r_aluwb",  1, OP_R, 0, 1, mk(4'd7, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1,1,0,0));

        // Jump.
        cyc("j_fetch",  1, OP_J, 0, 1, e_fetch(1));
        cyc("j_decode", 1, OP_J, 0, 1, e_decode(0));
        cyc("j_jump",   1, OP_J, 0, 1, mk(4'd9, 0,0,0,0,1, 2'b10, 0, 2'b00, 2'b00, 0,0,0,0));

        // Unsupported opcode: one-cycle illegal pulse, then back to FETCH.
        cyc("bad_fetch",  1, OP_BAD, 0, 1, e_fetch(1));
        cyc("bad_decode", 1, OP_BAD, 0, 1, e_decode(1));

        // addi: decoded only when the feature is built in.
        cyc("addi_fetch", 1, OP_ADDI, 0, 1, e_fetch(1));
`ifdef MC_CONTROL_ADDI_EN
        cyc("addi_decode", 1, OP_ADDI, 0, 1, e_decode(0));
        cyc("addi_ex",     1, OP_ADDI, 0, 1, mk(4'd10, 0,0,0,0,0, 2'b00, 1, 2'b10, 2'b00, 0,0,0,0));
        cyc("addi_wb",     1, OP_ADDI, 0, 1, mk(4'd11, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1,0,0,0));
`else
        cyc("addi_illegal", 1, OP_ADDI, 0, 1, e_decode(1));
`endif

        // lw aborted by reset in MEMWB: write enable drops at once.
        cyc("abort_fetch",  1, OP_LW, 0, 1, e_fetch(1));
        cyc("abort_decode", 1, OP_LW, 0, 1, e_decode(0));
        cyc("abort_memadr", 1, OP_LW, 0, 1, mk(4'd2, 0,0,0,0,0, 2'b00, 1, 2'b10, 2'b00, 0,0,0,0));
        cyc("abort_memrd",  1, OP_LW, 0, 1, mk(4'd3, 1,0,1,0,0, 2'b00, 0, 2'b00, 2'b00, 0,0,0,0));
        cyc("abort_reset",  0, OP_LW, 0, 1, e_reset());
        cyc("abort_refetch", 1, OP_LW, 0, 1, e_fetch(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
